// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher (InvCipher): one round transform per clock,
// sharing key bus, trigger/done handshake and byte order with the encrypt core.

module inv_s_box (
    input  logic [31:0] a,
    output logic [31:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] v;
        p = 8'h00;
        v = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ v;
            v = {v[6:0], 1'b0} ^ (8'h1b & {8{v[7]}});
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] inv_sub(input logic [7:0] s);
        logic [7:0] b;
        b = rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign y[8*i +: 8] = inv_sub(a[8*i +: 8]);
    end

endmodule

module aes_decrypt #(
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [128*(NR+1)-1:0]   w,
    input  logic [127:0]            in,
    input  logic                    trigger,
    output logic [127:0]            out,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ADD    = 3'd2,
        S_ISHIFT = 3'd3,
        S_ISUB   = 3'd4,
        S_IMIX   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t       cur, nxt;
    logic [3:0]   round_q, round_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_d;
    logic         done_d;
    logic [127:0] rk;
    logic [127:0] shift_st;
    logic [127:0] sub_st;
    logic [127:0] mix_st;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Column multiply by {0e,0b,0d,09} circulant, built from x2/x4/x8 partials.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Row r rotates right by r: new column c takes old column (c-r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-32*c-8*row -: 8] = s[127-32*((c-row+4)%4)-8*row -: 8];
            end
        end
        return r;
    endfunction

    always_comb begin
        rk = '0;
        for (int r = 0; r <= NR; r++) begin
            if (round_q == 4'(r)) rk = w[128*r +: 128];
        end
    end

    assign shift_st = inv_shift_rows(st_q);

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_s_box u_isb (
            .a (st_q[127-32*c -: 32]),
            .y (sub_st[127-32*c -: 32])
        );
        assign mix_st[127-32*c -: 32] = inv_mix_col(st_q[127-32*c -: 32]);
    end

    always_comb begin
        nxt     = cur;
        round_d = round_q;
        st_d    = st_q;
        out_d   = out;
        done_d  = done;
        unique case (cur)
            S_IDLE: begin
                done_d = 1'b0;
                if (trigger) begin
                    st_d    = in;
                    round_d = 4'(NR);
                    nxt     = S_LOAD;
                end
            end
            S_LOAD: nxt = S_ADD;
            S_ADD: begin
                st_d = st_q ^ rk;
                if (round_q == 4'd0) begin
                    nxt = S_DONE;
                end else if (round_q == 4'(NR)) begin
                    round_d = 4'(NR - 1);
                    nxt     = S_ISHIFT;
                end else begin
                    nxt = S_IMIX;
                end
            end
            S_ISHIFT: begin
                st_d = shift_st;
                nxt  = S_ISUB;
            end
            S_ISUB: begin
                st_d = sub_st;
                nxt  = S_ADD;
            end
            S_IMIX: begin
                st_d    = mix_st;
                round_d = round_q - 4'd1;
                nxt     = S_ISHIFT;
            end
            S_DONE: begin
                if (trigger) begin
                    st_d    = in;
                    round_d = 4'(NR);
                    done_d  = 1'b0;
                    nxt     = S_LOAD;
                end else begin
                    out_d  = st_q;
                    done_d = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_IDLE;
            round_q <= '0;
            st_q    <= '0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            cur     <= nxt;
            round_q <= round_d;
            st_q    <= st_d;
            out     <= out_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: byte-array AES-128 forward cipher and key expansion
// model, FIPS-197 vectors, random round trips, reset and handshake scenarios.

module tb_aes_decrypt;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1407:0]  w = '0;
    logic [127:0]   in = '0;
    logic           trigger = 1'b0;
    logic [127:0]   out;
    logic           done;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox [256];

    always #5 clk = ~clk;

    aes_decrypt dut (
        .clk     (clk),
        .reset   (reset),
        .w       (w),
        .in      (in),
        .trigger (trigger),
        .out     (out),
        .done    (done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int aa;
        p = 0;
        aa = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic int rot8(input int b, input int k);
        return ((b << k) | (b >> (8 - k))) & 255;
    endfunction

    task automatic build_sbox();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = y;
            s = inv ^ rot8(inv, 1) ^ rot8(inv, 2) ^ rot8(inv, 3) ^ rot8(inv, 4) ^ 'h63;
            sbox[x] = 8'(s);
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] kw;
        for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            wd[i] = wd[i-4] ^ t;
        end
        kw = '0;
        for (int r = 0; r < 11; r++)
            kw[128*r +: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
        return kw;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] p, input logic [1407:0] kw);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ kw[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            s = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kw[128*rnd+127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Called #1 after a rising edge; returns result, edges until done, and
    // done/out as seen just after the accepting edge.
    task automatic run_op(input logic [127:0] ct, input logic [1407:0] kw,
                          output logic [127:0] res, output int lat,
                          output logic d0, output logic [127:0] o0);
        w = kw;
        in = ct;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        d0 = done;
        o0 = out;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out;
    endtask

    logic [127:0] key1, ct1, pt1, key2, ct2, pt2;

    task automatic test_reset();
        trigger = 1'b1;
        in = {4{32'hdeadbeef}};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 128'h0) begin
            errors++;
            $display("FAIL reset_out: got %h want 0", out);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        trigger = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || out !== 128'h0) begin
            errors++;
            $display("FAIL idle_hold: done %b out %h want 0/0", done, out);
        end
    endtask

    task automatic test_fips_c1();
        logic [127:0] res, o0;
        int lat;
        logic d0;
        run_op(ct1, expand(key1), res, lat, d0, o0);
        checks++;
        if (res !== pt1) begin
            errors++;
            $display("FAIL c1_out: got %h want %h", res, pt1);
        end
        checks++;
        if (lat !== 42) begin
            errors++;
            $display("FAIL c1_latency: got %0d want 42", lat);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || out !== pt1) begin
            errors++;
            $display("FAIL c1_hold: done %b out %h want 1 %h", done, out, pt1);
        end
    endtask

    task automatic test_fips_b();
        logic [127:0] res, o0;
        int lat;
        logic d0;
        run_op(ct2, expand(key2), res, lat, d0, o0);
        checks++;
        if (res !== pt2 || lat !== 42) begin
            errors++;
            $display("FAIL b_out: got %h lat %0d want %h lat 42", res, lat, pt2);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0]  key, p, res, o0;
        logic [1407:0] kw;
        int lat;
        logic d0;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            p   = {$urandom, $urandom, $urandom, $urandom};
            kw  = expand(key);
            run_op(enc(p, kw), kw, res, lat, d0, o0);
            checks++;
            if (res !== p || lat !== 42) begin
                errors++;
                $display("FAIL round_trip[%0d]: got %h lat %0d want %h lat 42",
                         n, res, lat, p);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res, o0;
        int lat;
        logic d0;
        w = expand(key2);
        in = ct2;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 128'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out %h done %b want 0 0", out, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(ct1, expand(key1), res, lat, d0, o0);
        checks++;
        if (res !== pt1 || lat !== 42) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d want %h lat 42", res, lat, pt1);
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0]  key, p, ct;
        logic [1407:0] kw;
        key = {$urandom, $urandom, $urandom, $urandom};
        p   = {$urandom, $urandom, $urandom, $urandom};
        kw  = expand(key);
        ct  = enc(p, kw);
        w = kw;
        in = ct;
        trigger = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 41; k++) begin
            trigger = 1'($urandom);
            in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        trigger = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL busy_early_done: got %b want 0 after edge 41", done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || out !== p) begin
            errors++;
            $display("FAIL busy_ignore: done %b out %h want 1 %h", done, out, p);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res, o0, prev;
        int lat;
        logic d0;
        prev = out;
        run_op(ct2, expand(key2), res, lat, d0, o0);
        checks++;
        if (d0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_drop: got %b want 0", d0);
        end
        checks++;
        if (o0 !== prev) begin
            errors++;
            $display("FAIL b2b_out_held: got %h want %h", o0, prev);
        end
        checks++;
        if (res !== pt2 || lat !== 42) begin
            errors++;
            $display("FAIL b2b_result: got %h lat %0d want %h lat 42", res, lat, pt2);
        end
    endtask

    initial begin
        key1 = 128'h000102030405060708090a0b0c0d0e0f;
        ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt1  = 128'h00112233445566778899aabbccddeeff;
        key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
        pt2  = 128'h3243f6a8885a308d313198a2e0370734;
        build_sbox();
        #1;
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_round_trip();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
